// File: rtl/kiseonik_spremnik.sv
// Oxygen reservoir: counts production pulses into a bounded level and releases
// fixed-size packets over valid/ready, with full/empty, sticky overflow and packet count.
module kiseonik_spremnik #(
    parameter int unsigned KAPACITET = 15,
    parameter int unsigned PRAG      = 4,
    parameter int unsigned WIDTH     = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_kiseonik,
    input  logic             i_ispust_ready,
    input  logic             i_preliv_clr,
    output logic             o_ispust_valid,
    output logic [WIDTH-1:0] o_ispust_kolicina,
    output logic [WIDTH-1:0] o_nivo,
    output logic             o_pun,
    output logic             o_prazan,
    output logic             o_preliv,
    output logic [7:0]       o_broj_paketa
);

    localparam logic [WIDTH-1:0] KAP_W  = WIDTH'(KAPACITET);
    localparam logic [WIDTH-1:0] PRAG_W = WIDTH'(PRAG);
    localparam logic [WIDTH-1:0] JEDAN  = WIDTH'(1);

    typedef enum logic [1:0] {
        PRAZAN,
        PUNJENJE,
        ISPUST
    } stanje_e;

    stanje_e          state_q, state_d;
    logic [WIDTH-1:0] nivo_q, nivo_d;
    logic             preliv_q, preliv_d;
    logic [7:0]       broj_q, broj_d;
    logic             accept;
    logic             drop;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= PRAZAN;
            nivo_q   <= '0;
            preliv_q <= 1'b0;
            broj_q   <= '0;
        end else begin
            state_q  <= state_d;
            nivo_q   <= nivo_d;
            preliv_q <= preliv_d;
            broj_q   <= broj_d;
        end
    end

    // State follows the next level, so valid rises together with nivo >= PRAG.
    always_comb begin
        accept = (state_q == ISPUST) && i_ispust_ready;
        drop   = 1'b0;
        nivo_d = nivo_q;
        case ({i_kiseonik, accept})
            2'b10: begin
                if (nivo_q == KAP_W) drop = 1'b1;
                else                 nivo_d = nivo_q + JEDAN;
            end
            2'b01:   nivo_d = nivo_q - PRAG_W;
            2'b11:   nivo_d = nivo_q - PRAG_W + JEDAN;
            default: nivo_d = nivo_q;
        endcase
        preliv_d = drop | (preliv_q & ~i_preliv_clr);
        broj_d   = broj_q + {7'd0, accept};
        if (nivo_d == '0)          state_d = PRAZAN;
        else if (nivo_d < PRAG_W)  state_d = PUNJENJE;
        else                       state_d = ISPUST;
    end

    always_comb begin
        o_ispust_valid    = (state_q == ISPUST);
        o_ispust_kolicina = (state_q == ISPUST) ? PRAG_W : '0;
        o_nivo            = nivo_q;
        o_pun             = (nivo_q == KAP_W);
        o_prazan          = (nivo_q == '0);
        o_preliv          = preliv_q;
        o_broj_paketa     = broj_q;
    end

endmodule
